// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl
// -------------
// Password-check controller for the door lock. Collects a CODE_LEN-digit
// BCD code from one-cycle key pulses, compares it against PASSWORD on
// enter, and drives timed unlock / err / lockout indications.
//
// Interface contract: key_on, enter_on and clr_on are one-cycle "valid"
// pulses from the upstream edge detectors. There is no ready/backpressure:
// a pulse is either consumed in the cycle it is present or dropped. Within a
// cycle clr_on beats enter_on, which beats a digit key. A digit key is valid
// only when key_on is exactly one-hot.
//
// Optional feature: define DOORLOCK_LOCKOUT_EN to build the LOCKOUT state.
// Without it, lockout is constant 0 and fail_cnt is cleared only by a
// successful unlock or by reset.
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   key_on     [9:0] digit press pulses, bit i = digit i
//   enter_on   enter press pulse
//   clr_on     clear press pulse
//   unlock     door open indication (registered)
//   err        wrong-code indication (registered)
//   lockout    too-many-failures indication (registered)
//   digit_cnt  [3:0] digits entered so far
//   fail_cnt   [2:0] consecutive failures, saturating at 7
module doorlock_ctrl #(
  parameter int          CODE_LEN    = 4,
  parameter logic [31:0] PASSWORD    = 32'h0000_1234,
  parameter int          OPEN_CYCLES = 50_000_000,
  parameter int          ERR_CYCLES  = 25_000_000,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [9:0] key_on,
  input  logic       enter_on,
  input  logic       clr_on,
  output logic       unlock,
  output logic       err,
  output logic       lockout,
  output logic [3:0] digit_cnt,
  output logic [2:0] fail_cnt
);

`ifdef DOORLOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // Only the low CODE_LEN digits of the buffer take part in the compare.
  localparam logic [31:0] CODE_MASK   = 32'hFFFF_FFFF >> (32 - 4 * CODE_LEN);
  localparam logic [31:0] PASS_MASKED = PASSWORD & CODE_MASK;
  localparam logic [3:0]  CODE_LEN_C  = 4'(CODE_LEN);
  localparam logic [2:0]  LOCK_THRESH = 3'(MAX_FAIL);
  localparam logic [31:0] OPEN_LOAD   = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] ERR_LOAD    = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD   = 32'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_ERROR   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  fail_q, fail_d;
  logic [31:0] timer_q, timer_d;
  logic        unlock_q, err_q, lockout_q;

  logic [3:0]  key_digit;
  logic        key_valid;
  logic        key_act;
  logic        enter_act;
  logic        timer_done;
  logic        code_ok;

  // One-hot to BCD digit; only meaningful when key_valid is set.
  always_comb begin
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_on[i]) key_digit = 4'(i);
    end
  end

  assign key_valid  = $onehot(key_on);
  assign enter_act  = enter_on & ~clr_on;
  assign key_act    = key_valid & ~clr_on & ~enter_on;
  assign timer_done = (timer_q == 32'd0);
  assign code_ok    = (cnt_q == CODE_LEN_C) && ((buf_q & CODE_MASK) == PASS_MASKED);

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE: begin
        if (key_act) begin
          buf_d   = {buf_q[27:0], key_digit};
          cnt_d   = 4'd1;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (clr_on) begin
          buf_d   = 32'd0;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (enter_act) begin
          buf_d = 32'd0;
          cnt_d = 4'd0;
          if (code_ok) begin
            fail_d  = 3'd0;
            state_d = S_OPEN;
          end else begin
            if (fail_q != 3'd7) fail_d = fail_q + 3'd1;
            state_d = S_ERROR;
          end
        end else if (key_act && (cnt_q < CODE_LEN_C)) begin
          buf_d = {buf_q[27:0], key_digit};
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_OPEN: begin
        if (timer_done) state_d = S_IDLE;
      end

      S_ERROR: begin
        if (timer_done) begin
          if (LOCK_EN && (fail_q >= LOCK_THRESH)) state_d = S_LOCKOUT;
          else                                    state_d = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (timer_done) begin
          fail_d  = 3'd0;
          state_d = S_IDLE;
        end
      end

      default: begin
        buf_d   = 32'd0;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Timer loads on entry to a timed state and then counts down to 0; the
  // state is left in the cycle where the counter already reads 0, giving
  // exactly X_CYCLES cycles of indication.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      case (state_d)
        S_OPEN:    timer_d = OPEN_LOAD;
        S_ERROR:   timer_d = ERR_LOAD;
        S_LOCKOUT: timer_d = LOCK_LOAD;
        default:   timer_d = 32'd0;
      endcase
    end else if (!timer_done) begin
      timer_d = timer_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      buf_q     <= 32'd0;
      cnt_q     <= 4'd0;
      fail_q    <= 3'd0;
      timer_q   <= 32'd0;
      unlock_q  <= 1'b0;
      err_q     <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      // Indications are decoded from the next state so they line up with
      // the state register and never overlap.
      unlock_q  <= (state_d == S_OPEN);
      err_q     <= (state_d == S_ERROR);
      lockout_q <= LOCK_EN && (state_d == S_LOCKOUT);
    end
  end

  assign unlock    = unlock_q;
  assign err       = err_q;
  assign lockout   = lockout_q;
  assign digit_cnt = cnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl
// ----------------
// Self-checking bench for doorlock_ctrl. Each expected indication window is
// encoded as {kind[1:0], length[7:0], fail_cnt_at_end[2:0]} and pushed when
// the stimulus that causes it is issued. A monitor watches unlock/err/lockout
// on the falling edge, measures each window and pops/compares on its end.
// kind: 1 = unlock, 2 = err, 3 = lockout.
module tb_doorlock_ctrl;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [9:0] key_on = '0;
  logic       enter_on = 1'b0;
  logic       clr_on = 1'b0;
  logic       unlock, err, lockout;
  logic [3:0] digit_cnt;
  logic [2:0] fail_cnt;

  doorlock_ctrl #(
    .CODE_LEN    (4),
    .PASSWORD    (32'h0000_1234),
    .OPEN_CYCLES (8),
    .ERR_CYCLES  (4),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_on    (key_on),
    .enter_on  (enter_on),
    .clr_on    (clr_on),
    .unlock    (unlock),
    .err       (err),
    .lockout   (lockout),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] ev(input logic [1:0] kind, input int len,
                                      input logic [2:0] fail);
    return {kind, 8'(len), fail};
  endfunction

  // Scoreboard monitor
  logic [1:0] cur_kind = 2'd0;
  int         cur_len  = 0;

  always @(negedge clk) begin : monitor
    logic [1:0]   k_now;
    logic [W-1:0] obs;
    logic [W-1:0] want;
    if (!n_rst) begin
      cur_kind = 2'd0;
      cur_len  = 0;
    end else begin
      checks++;
      if ($countones({unlock, err, lockout}) > 1) begin
        errors++;
        $display("FAIL exclusive_outputs got unlock=%0b err=%0b lockout=%0b expected at most one high",
                 unlock, err, lockout);
      end
      k_now = unlock ? 2'd1 : err ? 2'd2 : lockout ? 2'd3 : 2'd0;
      if (k_now != cur_kind) begin
        if (cur_kind != 2'd0) begin
          obs = {cur_kind, 8'(cur_len), fail_cnt};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL window_unexpected got kind=%0d len=%0d fail_cnt=%0d expected no window",
                     cur_kind, cur_len, fail_cnt);
          end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
              errors++;
              $display("FAIL window got kind=%0d len=%0d fail_cnt=%0d expected kind=%0d len=%0d fail_cnt=%0d",
                       obs[12:11], obs[10:3], obs[2:0], want[12:11], want[10:3], want[2:0]);
            end
          end
        end
        cur_kind = k_now;
        cur_len  = (k_now != 2'd0) ? 1 : 0;
      end else if (cur_kind != 2'd0) begin
        cur_len++;
      end
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [9:0] k, input logic e, input logic c);
    @(negedge clk);
    key_on   = k;
    enter_on = e;
    clr_on   = c;
    @(negedge clk);
    key_on   = '0;
    enter_on = 1'b0;
    clr_on   = 1'b0;
  endtask

  task automatic key_chk(input int d, input int exp_cnt);
    logic [9:0] k;
    k = 10'd1 << d;
    press(k, 1'b0, 1'b0);
    check("digit_cnt", 32'(digit_cnt), 32'(exp_cnt));
  endtask

  task automatic enter();
    press(10'd0, 1'b1, 1'b0);
    check("digit_cnt_after_enter", 32'(digit_cnt), 0);
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    key_chk(a, 1);
    key_chk(b, 2);
    key_chk(c, 3);
    key_chk(d, 4);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    // Reset state
    #2 n_rst = 1'b0;
    #1;
    check("rst_unlock", 32'(unlock), 0);
    check("rst_err", 32'(err), 0);
    check("rst_lockout", 32'(lockout), 0);
    check("rst_digit_cnt", 32'(digit_cnt), 0);
    check("rst_fail_cnt", 32'(fail_cnt), 0);
    @(negedge clk);
    #2 n_rst = 1'b1;

    // Correct code
    code4(1, 2, 3, 4);
    exp_q.push_back(ev(2'd1, 8, 3'd0));
    enter();
    check("open_unlock_first_cycle", 32'(unlock), 1);
    wait_cycles(10);
    check("open_done_unlock", 32'(unlock), 0);
    check("open_done_fail_cnt", 32'(fail_cnt), 0);

    // Wrong code, then correct code clears fail_cnt
    code4(1, 2, 3, 5);
    exp_q.push_back(ev(2'd2, 4, 3'd1));
    enter();
    check("wrong_err_first_cycle", 32'(err), 1);
    check("wrong_fail_cnt", 32'(fail_cnt), 1);
    wait_cycles(6);
    code4(1, 2, 3, 4);
    exp_q.push_back(ev(2'd1, 8, 3'd0));
    enter();
    check("recover_fail_cnt", 32'(fail_cnt), 0);
    wait_cycles(10);

    // Short code
    key_chk(1, 1);
    key_chk(2, 2);
    key_chk(3, 3);
    exp_q.push_back(ev(2'd2, 4, 3'd1));
    enter();
    wait_cycles(6);
    check("short_fail_cnt", 32'(fail_cnt), 1);

    // Overflow: extra digits are ignored
    code4(1, 2, 3, 4);
    key_chk(9, 4);
    key_chk(9, 4);
    exp_q.push_back(ev(2'd1, 8, 3'd0));
    enter();
    wait_cycles(10);

    // Clear keeps fail_cnt
    code4(9, 9, 9, 9);
    exp_q.push_back(ev(2'd2, 4, 3'd1));
    enter();
    wait_cycles(6);
    key_chk(1, 1);
    key_chk(2, 2);
    press(10'd0, 1'b0, 1'b1);
    check("clr_digit_cnt", 32'(digit_cnt), 0);
    check("clr_fail_cnt", 32'(fail_cnt), 1);

    // clr and enter together: clear wins, no err
    key_chk(1, 1);
    press(10'd0, 1'b1, 1'b1);
    check("clr_enter_digit_cnt", 32'(digit_cnt), 0);
    check("clr_enter_err", 32'(err), 0);
    check("clr_enter_fail_cnt", 32'(fail_cnt), 1);

    // enter in IDLE is ignored
    press(10'd0, 1'b1, 1'b0);
    check("idle_enter_err", 32'(err), 0);

    // Two-hot key is ignored, in IDLE and in ENTRY
    press(10'b0000000011, 1'b0, 1'b0);
    check("twohot_idle_digit_cnt", 32'(digit_cnt), 0);
    key_chk(1, 1);
    press(10'b0000000011, 1'b0, 1'b0);
    check("twohot_entry_digit_cnt", 32'(digit_cnt), 1);
    key_chk(2, 2);
    key_chk(3, 3);
    key_chk(4, 4);
    exp_q.push_back(ev(2'd1, 8, 3'd0));
    enter();
    wait_cycles(10);
    check("twohot_fail_cnt", 32'(fail_cnt), 0);

    // Three consecutive failures
    code4(5, 5, 5, 5);
    exp_q.push_back(ev(2'd2, 4, 3'd1));
    enter();
    wait_cycles(6);
    code4(5, 5, 5, 5);
    exp_q.push_back(ev(2'd2, 4, 3'd2));
    enter();
    wait_cycles(6);
    code4(5, 5, 5, 5);
    exp_q.push_back(ev(2'd2, 4, 3'd3));
`ifdef DOORLOCK_LOCKOUT_EN
    exp_q.push_back(ev(2'd3, 16, 3'd0));
    enter();
    wait_cycles(6);
    check("lockout_high", 32'(lockout), 1);
    check("lockout_fail_cnt", 32'(fail_cnt), 3);
    key_chk(1, 0);
    key_chk(2, 0);
    wait_cycles(20);
    check("lockout_done", 32'(lockout), 0);
    check("lockout_done_fail_cnt", 32'(fail_cnt), 0);
    check("lockout_done_digit_cnt", 32'(digit_cnt), 0);
`else
    enter();
    wait_cycles(6);
    check("nolock_lockout", 32'(lockout), 0);
    check("nolock_fail_cnt", 32'(fail_cnt), 3);
    key_chk(1, 1);
    press(10'd0, 1'b0, 1'b1);
    check("nolock_clr_digit_cnt", 32'(digit_cnt), 0);
    check("nolock_fail_cnt_kept", 32'(fail_cnt), 3);
    wait_cycles(20);
    check("nolock_lockout_late", 32'(lockout), 0);
`endif

    // Reset mid-OPEN (timer at 5): no window expected for the cut-off open
    code4(1, 2, 3, 4);
    enter();
    wait_cycles(2);
    check("pre_rst_unlock", 32'(unlock), 1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_open_unlock", 32'(unlock), 0);
    check("rst_open_err", 32'(err), 0);
    check("rst_open_lockout", 32'(lockout), 0);
    check("rst_open_digit_cnt", 32'(digit_cnt), 0);
    wait_cycles(2);
    #2 n_rst = 1'b1;
    code4(1, 2, 3, 4);
    exp_q.push_back(ev(2'd1, 8, 3'd0));
    enter();
    wait_cycles(10);

    // Reset mid-ENTRY with two digits entered
    key_chk(7, 1);
    key_chk(8, 2);
    #2 n_rst = 1'b0;
    #1;
    check("rst_entry_digit_cnt", 32'(digit_cnt), 0);
    check("rst_entry_fail_cnt", 32'(fail_cnt), 0);
    wait_cycles(2);
    #2 n_rst = 1'b1;
    code4(1, 2, 3, 4);
    exp_q.push_back(ev(2'd1, 8, 3'd0));
    enter();
    wait_cycles(12);

    // Final report
    check("pending_windows", 32'(exp_q.size()), 0);
    check("open_window_at_end", 32'(cur_kind), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
